// File: rtl/fila_de_instrucoes_multi.sv
// Dual-issue instruction queue prefetching from synchronous instruction memory.
// Define FILA_STALL_CNT_EN to build the saturating empty-stall counter.
module fila_de_instrucoes_multi #(
  parameter int                DATA_W    = 16,
  parameter int                DEPTH     = 16,
  parameter int                PC_W      = 8,
  parameter logic [DATA_W-1:0] SEM_VALOR = '0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  output logic                       Mem_Req,
  output logic [PC_W-1:0]            Mem_Addr,
  input  logic [DATA_W-1:0]          Mem_Data,
  input  logic [1:0]                 Pop_Count,
  input  logic                       Flush,
  input  logic [PC_W-1:0]            Flush_PC,
  output logic [DATA_W-1:0]          Instr0,
  output logic [DATA_W-1:0]          Instr1,
  output logic                       Valid0,
  output logic                       Valid1,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Full,
  output logic                       Empty,
  output logic [15:0]                Stall_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] fila [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [AW-1:0]     head1;
  logic [CW-1:0]     count;
  logic [CW-1:0]     occ;
  logic [PC_W-1:0]   pc;
  logic              inflight;
  logic [1:0]        pop_req;
  logic [1:0]        pop;

  // Credit counts the in-flight request so a returning word always has room.
  assign occ      = count + CW'(inflight);
  assign Mem_Req  = Reset && !Flush && (occ < CW'(DEPTH));
  assign Mem_Addr = pc;

  assign pop_req = Pop_Count[1] ? 2'd2 : Pop_Count;
  assign pop     = (CW'(pop_req) > count) ? count[1:0] : pop_req;
  assign head1   = head + AW'(1);

  assign Valid0 = (count != '0);
  assign Valid1 = (count >= CW'(2));
  assign Instr0 = Valid0 ? fila[head]  : SEM_VALOR;
  assign Instr1 = Valid1 ? fila[head1] : SEM_VALOR;
  assign Count  = count;
  assign Full   = (count == CW'(DEPTH));
  assign Empty  = (count == '0);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pc       <= '0;
      inflight <= 1'b0;
    end else if (Flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      pc       <= Flush_PC;
      inflight <= 1'b0;
    end else begin
      head     <= head + AW'(pop);
      count    <= count + CW'(inflight) - CW'(pop);
      inflight <= Mem_Req;
      if (inflight) tail <= tail + AW'(1);
      if (Mem_Req)  pc   <= pc + PC_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset && !Flush && inflight)
      fila[tail] <= Mem_Data;
  end

`ifdef FILA_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge Clock) begin
    if (!Reset || Flush)
      stall_cnt <= '0;
    else if (Pop_Count != 2'd0 && count == '0 && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign Stall_Count = stall_cnt;
`else
  assign Stall_Count = '0;
`endif

endmodule

// File: tb/tb_fila_de_instrucoes_multi.sv
// Randomised and directed bench for fila_de_instrucoes_multi.
// Reference model: a queue of expected words plus one in-flight address.
module tb_fila_de_instrucoes_multi;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  pop_count;
  logic        flush;
  logic [7:0]  flush_pc;
  logic [15:0] instr0;
  logic [15:0] instr1;
  logic        valid0;
  logic        valid1;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] stall_count;

  int checks;
  int failures;

  fila_de_instrucoes_multi dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .Mem_Req     (mem_req),
    .Mem_Addr    (mem_addr),
    .Mem_Data    (mem_data),
    .Pop_Count   (pop_count),
    .Flush       (flush),
    .Flush_PC    (flush_pc),
    .Instr0      (instr0),
    .Instr1      (instr1),
    .Valid0      (valid0),
    .Valid1      (valid1),
    .Count       (count),
    .Full        (full),
    .Empty       (empty),
    .Stall_Count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: Q = A000 + address, one cycle after the request
  always @(posedge clk)
    if (mem_req) mem_data <= 16'hA000 + {8'h00, mem_addr};

  logic [15:0] q[$];
  int          mpc;
  bit          minf;
  int          minf_addr;
  int          mstall;
`ifdef FILA_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input int p, input bit f, input int fpc);
    bit          ereq;
    int          sz;
    int          np;
    logic [15:0] e0;
    logic [15:0] e1;
    rst_n     = r;
    pop_count = p[1:0];
    flush     = f;
    flush_pc  = fpc[7:0];
    #1;
    sz   = q.size();
    ereq = r && !f && (sz + int'(minf) < 16);
    e0   = (sz >= 1) ? q[0] : 16'h0000;
    e1   = (sz >= 2) ? q[1] : 16'h0000;
    chk("mem_req", {31'd0, mem_req}, {31'd0, ereq});
    if (ereq) chk("mem_addr", {24'd0, mem_addr}, mpc);
    chk("instr0", {16'd0, instr0}, {16'd0, e0});
    chk("instr1", {16'd0, instr1}, {16'd0, e1});
    chk("valid0", {31'd0, valid0}, {31'd0, sz >= 1});
    chk("valid1", {31'd0, valid1}, {31'd0, sz >= 2});
    chk("count", {27'd0, count}, sz);
    chk("full", {31'd0, full}, {31'd0, sz == 16});
    chk("empty", {31'd0, empty}, {31'd0, sz == 0});
    chk("stall_count", {16'd0, stall_count}, mstall);
    @(posedge clk);
    if (!r) begin
      q.delete(); mpc = 0; minf = 0; mstall = 0;
    end else if (f) begin
      q.delete(); mpc = fpc & 255; minf = 0; mstall = 0;
    end else begin
      if (STALL_EN && p != 0 && sz == 0 && mstall < 65535) mstall++;
      np = (p > 2) ? 2 : p;
      if (np > sz) np = sz;
      repeat (np) void'(q.pop_front());
      if (minf) q.push_back(16'hA000 + 16'(minf_addr));
      minf = ereq;
      minf_addr = mpc;
      if (ereq) mpc = (mpc + 1) % 256;
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    mpc = 0; minf = 0; minf_addr = 0; mstall = 0;
    rst_n = 1'b0; pop_count = 2'd0; flush = 1'b0; flush_pc = 8'h00;
    @(negedge clk);
    repeat (3) step(0, 0, 0, 0);
    chk("reset_empty", {31'd0, empty}, 32'd1);
    repeat (20) step(1, 0, 0, 0);
    chk("fill_count", {27'd0, count}, 32'd16);
    chk("fill_instr0", {16'd0, instr0}, 32'hA000);
    step(1, 2, 0, 0);
    chk("pop2_instr0", {16'd0, instr0}, 32'hA002);
    repeat (6) step(1, 0, 0, 0);
    repeat (40) step(1, 1, 0, 0);
    step(1, 0, 1, 'h40);
    repeat (4) step(1, 0, 0, 0);
    repeat (8) step(1, 2, 0, 0);
    step(1, 3, 1, 'hF8);
    repeat (40) step(1, 1, 0, 0);
    step(1, 0, 1, 'h10);
    repeat (5) step(1, 1, 0, 0);
    repeat (5) step(1, 3, 0, 0);
    step(0, 2, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 700; i++) begin
      int  p;
      bit  r;
      bit  f;
      r = ($urandom_range(0, 99) != 0);
      f = ($urandom_range(0, 99) < 3);
      p = (i % 100 < 50) ? $urandom_range(0, 1) : $urandom_range(0, 3);
      step(r, p, f, $urandom_range(0, 255));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
